// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci XNOR LFSR with a valid/ready word output.
// Define LFSR_PERIOD_CNT_EN to add the period_cnt / period_hit outputs.
module lfsr_gen #(
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] TAPS     = 16'hD008,
    parameter logic [WIDTH-1:0] SEED     = 16'h0001,
    parameter int unsigned      OUT_BITS = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                seed_load,
    input  logic [WIDTH-1:0]    seed_in,
    output logic [OUT_BITS-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    state_out,
    output logic                lockup_flag
`ifdef LFSR_PERIOD_CNT_EN
    ,
    output logic [WIDTH-1:0]    period_cnt,
    output logic                period_hit
`endif
);

    generate
        if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
            $error("lfsr_gen: WIDTH must be in 3..32");
        end
        if (OUT_BITS < 1 || OUT_BITS > WIDTH) begin : g_bad_out_bits
            $error("lfsr_gen: OUT_BITS must be in 1..WIDTH");
        end
        if (SEED == {WIDTH{1'b1}}) begin : g_bad_seed
            $error("lfsr_gen: SEED must not be all-ones");
        end
    endgenerate

    logic [WIDTH-1:0]    s;
    logic [WIDTH-1:0]    s_next;
    logic [WIDTH-1:0]    walk;
    logic [OUT_BITS-1:0] word;
    logic                load;
    logic                seed_bad;
    logic [WIDTH-1:0]    seed_fix;

    // OUT_BITS steps unrolled; the first emitted bit lands in the MSB.
    always_comb begin
        walk = s;
        word = '0;
        for (int i = 0; i < OUT_BITS; i++) begin
            word[OUT_BITS-1-i] = walk[WIDTH-1];
            walk = {walk[WIDTH-2:0], ~^(walk & TAPS)};
        end
        s_next = walk;
    end

    assign load      = en && (!out_valid || out_ready);
    assign seed_bad  = &seed_in;
    assign seed_fix  = seed_bad ? SEED : seed_in;
    assign state_out = s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s           <= SEED;
            out_data    <= '0;
            out_valid   <= 1'b0;
            lockup_flag <= 1'b0;
        end else if (seed_load) begin
            s         <= seed_fix;
            out_valid <= 1'b0;
            if (seed_bad) begin
                lockup_flag <= 1'b1;
            end
        end else if (load) begin
            s         <= s_next;
            out_data  <= word;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef LFSR_PERIOD_CNT_EN
    logic [WIDTH-1:0] seed_ref;

    // A hit only counts when a word boundary lands exactly on the seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed_ref   <= SEED;
            period_cnt <= '0;
            period_hit <= 1'b0;
        end else if (seed_load) begin
            seed_ref   <= seed_fix;
            period_cnt <= '0;
            period_hit <= 1'b0;
        end else if (load) begin
            period_cnt <= period_cnt + WIDTH'(OUT_BITS);
            period_hit <= (s_next == seed_ref);
        end else begin
            period_hit <= 1'b0;
        end
    end
`endif

endmodule
